// File: rtl/cpu2_pkg.sv
// Shared types and constants for the cpu2 accumulator machine:
// opcode and sequencer encodings, default widths and RAM power-up image.
package cpu2_pkg;

   localparam int DEF_WORD_W = 8;
   localparam int DEF_OP_W   = 3;
   localparam int DEF_DEPTH  = 2 ** (DEF_WORD_W - DEF_OP_W);

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_STORE = 3'b001,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_BNE   = 3'b100,
      OP_IN    = 3'b101,
      OP_OUT   = 3'b110,
      OP_HALT  = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      S0_FETCH,
      S1_READ,
      S2_DECODE,
      S3_EXEC,
      S4_WB,
      S_HALTED
   } state_t;

   // Demo program: IN; ADD 30; STORE 31; OUT; LOAD 29; BNE 0
   localparam logic [DEF_WORD_W-1:0] RAM_INIT [DEF_DEPTH] = '{
      0: 8'hA0, 1: 8'h5E, 2: 8'h3F, 3: 8'hC0, 4: 8'h1D, 5: 8'h80,
      29: 8'h01, 30: 8'h01,
      default: 8'h00
   };

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low 7-segment decoder (bit0 = a ... bit6 = g).
module hex7seg (
   input  logic [3:0] val,
   output logic [6:0] seg
);

   always_comb begin
      seg = '1;
      case (val)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = '1;
      endcase
   end

endmodule

// File: rtl/cpu2.sv
// Multi-cycle accumulator CPU with 32-word RAM, switch input and four
// hex displays showing OUTREG and ACC.
module cpu2
   import cpu2_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int OP_W   = DEF_OP_W,
   parameter logic [WORD_W-1:0] INIT [2**(WORD_W-OP_W)] = RAM_INIT
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic [WORD_W-1:0] sw,
   output logic [6:0]        disp0,
   output logic [6:0]        disp1,
   output logic [6:0]        disp2,
   output logic [6:0]        disp3
);

   localparam int AW    = WORD_W - OP_W;
   localparam int DEPTH = 2 ** AW;

   logic [WORD_W-1:0] acc, ir, mdr, outreg;
   logic [AW-1:0]     pc, mar;
   // Power-up image only; reset deliberately leaves RAM untouched
   logic [WORD_W-1:0] ram [DEPTH] = INIT;

   state_t  state, state_nx;
   opcode_t op;

   logic mar_from_pc, fetch, decode, mem_rd, ram_we;
   logic acc_sw, out_ld, branch, wb;

   assign op = opcode_t'(ir[WORD_W-1 -: OP_W]);

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) state <= S0_FETCH;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      mar_from_pc = 1'b0;
      fetch       = 1'b0;
      decode      = 1'b0;
      mem_rd      = 1'b0;
      ram_we      = 1'b0;
      acc_sw      = 1'b0;
      out_ld      = 1'b0;
      branch      = 1'b0;
      wb          = 1'b0;
      case (state)
         S0_FETCH: begin
            mar_from_pc = 1'b1;
            state_nx    = S1_READ;
         end
         S1_READ: begin
            fetch    = 1'b1;
            state_nx = S2_DECODE;
         end
         S2_DECODE: begin
            decode   = 1'b1;
            state_nx = S3_EXEC;
         end
         S3_EXEC: begin
            state_nx = S0_FETCH;
            case (op)
               OP_LOAD, OP_ADD, OP_SUB: begin
                  mem_rd   = 1'b1;
                  state_nx = S4_WB;
               end
               OP_STORE: ram_we   = 1'b1;
               OP_IN:    acc_sw   = 1'b1;
               OP_OUT:   out_ld   = 1'b1;
               OP_BNE:   branch   = (acc != '0);
               OP_HALT:  state_nx = S_HALTED;
               default:  state_nx = S0_FETCH;
            endcase
         end
         S4_WB: begin
            wb       = 1'b1;
            state_nx = S0_FETCH;
         end
         S_HALTED: state_nx = S_HALTED;
         default:  state_nx = S0_FETCH;
      endcase
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         acc    <= '0;
         pc     <= '0;
         ir     <= '0;
         mar    <= '0;
         mdr    <= '0;
         outreg <= '0;
      end else begin
         if (mar_from_pc) mar <= pc;
         if (fetch) begin
            mdr <= ram[mar];
            pc  <= pc + AW'(1);
         end
         if (decode) begin
            ir  <= mdr;
            mar <= mdr[AW-1:0];
         end
         if (mem_rd) mdr    <= ram[mar];
         if (acc_sw) acc    <= sw;
         if (out_ld) outreg <= acc;
         if (branch) pc     <= mar;
         if (wb) begin
            case (op)
               OP_ADD:  acc <= acc + mdr;
               OP_SUB:  acc <= acc - mdr;
               default: acc <= mdr;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (ram_we) ram[mar] <= acc;
   end

   // MAR carries the operand address throughout execute
   a_mar_operand: assert property (@(posedge clock) disable iff (!n_reset)
      (state == S3_EXEC) |-> (mar == ir[AW-1:0]));

   hex7seg u_disp0 (.val(outreg[3:0]), .seg(disp0));
   hex7seg u_disp1 (.val(outreg[7:4]), .seg(disp1));
   hex7seg u_disp2 (.val(acc[3:0]),    .seg(disp2));
   hex7seg u_disp3 (.val(acc[7:4]),    .seg(disp3));

endmodule

// File: tb/tb_cpu2.sv
// Directed scoreboard bench for cpu2: demo program, wrap, reset abort,
// HALT and SUB/BNE programs on separately initialised instances.
module tb_cpu2;
   import cpu2_pkg::*;

   logic       clock = 1'b0;
   logic       n_reset, rst_h_n, rst_s_n;
   logic [7:0] sw;
   logic [6:0] d0, d1, d2, d3;
   logic [6:0] h0, h1, h2, h3;
   logic [6:0] s0, s1, s2, s3;

   localparam logic [7:0] HALT_INIT [32] = '{0: 8'hE0, default: 8'h00};
   localparam logic [7:0] SUB_INIT  [32] = '{
      0: 8'h7E, 1: 8'h83, 2: 8'hE0, 3: 8'hC0, 4: 8'hE0, 30: 8'h01,
      default: 8'h00
   };

   always #5 clock = ~clock;

   cpu2 dut (
      .clock(clock), .n_reset(n_reset), .sw(sw),
      .disp0(d0), .disp1(d1), .disp2(d2), .disp3(d3)
   );

   cpu2 #(.INIT(HALT_INIT)) dut_h (
      .clock(clock), .n_reset(rst_h_n), .sw(sw),
      .disp0(h0), .disp1(h1), .disp2(h2), .disp3(h3)
   );

   cpu2 #(.INIT(SUB_INIT)) dut_s (
      .clock(clock), .n_reset(rst_s_n), .sw(sw),
      .disp0(s0), .disp1(s1), .disp2(s2), .disp3(s3)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sbq[$];
   int  errors = 0;
   int  checks = 0;

   task automatic push(input string tag, input logic [31:0] e);
      sb_t x;
      x.tag = tag;
      x.exp = e;
      sbq.push_back(x);
   endtask

   task automatic check(input logic [31:0] obs);
      sb_t x;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: observed %0h expected none", obs);
         return;
      end
      x = sbq.pop_front();
      assert (obs === x.exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
      end
   endtask

   // Advance n rising edges, then settle on the following falling edge
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      sw      = 8'h41;
      n_reset = 1'b1;
      rst_h_n = 1'b0;
      rst_s_n = 1'b0;
      #2 n_reset = 1'b0;

      // reset held: displays show 0, PC at 0, sequencer in fetch
      push("rst_disp0", 32'h40); push("rst_disp1", 32'h40);
      push("rst_disp2", 32'h40); push("rst_disp3", 32'h40);
      push("rst_pc", 32'h0);     push("rst_state", 32'(S0_FETCH));
      repeat (2) @(negedge clock);
      check(32'(d0)); check(32'(d1)); check(32'(d2)); check(32'(d3));
      check(32'(dut.pc)); check(32'(dut.state));

      // IN 41; ADD 30; STORE 31; OUT -> 17 cycles
      n_reset = 1'b1;
      push("a_outreg", 32'h42); push("a_disp1", 32'h19); push("a_disp0", 32'h24);
      push("a_disp3", 32'h19);  push("a_disp2", 32'h24); push("a_pc", 32'h4);
      push("a_ram31", 32'h42);
      step(17);
      check(32'(dut.outreg)); check(32'(d1)); check(32'(d0));
      check(32'(d3)); check(32'(d2)); check(32'(dut.pc));
      check(32'(dut.ram[31]));
      push("a_load_acc", 32'h01); push("a_load_disp2", 32'h79);
      step(5);
      check(32'(dut.acc)); check(32'(d2));
      push("a_bne_pc", 32'h0); push("a_bne_state", 32'(S0_FETCH));
      step(4);
      check(32'(dut.pc)); check(32'(dut.state));

      // wrap run with sw=FF; RAM[31] must survive reset
      n_reset = 1'b0;
      sw      = 8'hFF;
      push("b_ram31_kept", 32'h42); push("b_rst_acc", 32'h0);
      @(negedge clock);
      check(32'(dut.ram[31])); check(32'(dut.acc));
      n_reset = 1'b1;
      push("b_add_wrap", 32'h00);
      step(9);
      check(32'(dut.acc));
      push("b_outreg", 32'h00); push("b_ram31", 32'h00); push("b_disp1", 32'h40);
      step(8);
      check(32'(dut.outreg)); check(32'(dut.ram[31])); check(32'(d1));
      push("b_acc", 32'h01); push("b_pc", 32'h0);
      step(9);
      check(32'(dut.acc)); check(32'(dut.pc));

      // reset asserted during S4 of the ADD
      n_reset = 1'b0;
      sw      = 8'h41;
      @(negedge clock);
      n_reset = 1'b1;
      push("c_in_s4", 32'(S4_WB)); push("c_acc_pre", 32'h41);
      step(8);
      check(32'(dut.state)); check(32'(dut.acc));
      n_reset = 1'b0;
      push("c_abort_acc", 32'h0); push("c_abort_state", 32'(S0_FETCH));
      push("c_abort_pc", 32'h0);
      #1;
      check(32'(dut.acc)); check(32'(dut.state)); check(32'(dut.pc));
      @(negedge clock);
      n_reset = 1'b1;
      push("c_mar", 32'h0); push("c_state_s1", 32'(S1_READ));
      step(1);
      check(32'(dut.mar)); check(32'(dut.state));
      push("c_mdr", 32'hA0); push("c_pc", 32'h1);
      step(1);
      check(32'(dut.mdr)); check(32'(dut.pc));

      // HALT at address 0
      rst_h_n = 1'b1;
      push("h_s3", 32'(S3_EXEC));
      step(3);
      check(32'(dut_h.state));
      push("h_halted", 32'(S_HALTED));
      step(1);
      check(32'(dut_h.state));
      push("h_still", 32'(S_HALTED)); push("h_pc", 32'h1);
      push("h_disp0", 32'h40); push("h_disp3", 32'h40);
      step(10);
      check(32'(dut_h.state)); check(32'(dut_h.pc));
      check(32'(h0)); check(32'(h3));

      // SUB 1 from 0, then BNE taken to the OUT at address 3
      rst_s_n = 1'b1;
      push("s_acc", 32'hFF); push("s_disp3", 32'h0E);
      step(5);
      check(32'(dut_s.acc)); check(32'(s3));
      push("s_bne_pc", 32'h3);
      step(4);
      check(32'(dut_s.pc));
      push("s_outreg", 32'hFF); push("s_disp1", 32'h0E);
      step(4);
      check(32'(dut_s.outreg)); check(32'(s1));
      push("s_halted", 32'(S_HALTED));
      step(4);
      check(32'(dut_s.state));

      if (sbq.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_leftover: observed %0d expected 0", sbq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
